// File: rtl/mem_arbiter.sv
// Arbitrates one unified RAM port between instruction fetch and data access.
// Data wins by default; a saturating starvation counter forces a pending fetch through.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    // instruction-fetch side
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [DATA_W-1:0] iload,
    output logic              iwait,
    // data-access side
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic [DATA_W-1:0] dload,
    output logic              dwait,
    // RAM side
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic              ramready
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] store_q, store_d;
    logic              wr_q, wr_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;

    logic pick_en;
    logic d_req;
    logic i_forced;

    // A new grant is chosen from IDLE every cycle, or when the current access completes;
    // a withdrawn request never shortens an access already on the RAM port.
    assign pick_en  = (state_q == IDLE) || ramready;
    assign d_req    = dREN || dWEN;
    assign i_forced = iREN && (starve_cnt_q == STARVE_LIM);

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through this block infers a latch.
        state_d      = state_q;
        addr_d       = addr_q;
        store_d      = store_q;
        wr_d         = wr_q;
        starve_cnt_d = starve_cnt_q;

        if (pick_en) begin
            if (d_req && !i_forced) begin
                state_d = DGRANT;
                addr_d  = daddr;
                store_d = dstore;
                wr_d    = dWEN;
                if (!iREN) begin
                    starve_cnt_d = '0;
                end else if (starve_cnt_q != STARVE_LIM) begin
                    starve_cnt_d = starve_cnt_q + 1'b1;
                end
            end else if (iREN) begin
                state_d      = IGRANT;
                addr_d       = iaddr;
                store_d      = '0;
                wr_d         = 1'b0;
                starve_cnt_d = '0;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            store_q      <= '0;
            wr_q         <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking updates keep every register sampling pre-edge values.
            state_q      <= state_d;
            addr_q       <= addr_d;
            store_q      <= store_d;
            wr_q         <= wr_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Strobes decode straight from registered state, so reset drops them without a glitch.
    assign ramREN   = (state_q == IGRANT) || ((state_q == DGRANT) && !wr_q);
    assign ramWEN   = (state_q == DGRANT) && wr_q;
    assign ramaddr  = addr_q;
    assign ramstore = store_q;

    assign iwait = !((state_q == IGRANT) && ramready);
    assign dwait = !((state_q == DGRANT) && ramready);
    assign iload = (state_q == IGRANT) ? ramload : '0;
    assign dload = (state_q == DGRANT) ? ramload : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: drivers push expected completions, a negedge monitor
// pops and compares them; directed cycle checks cover ordering, latching and reset.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SM = 4;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          iREN, dREN, dWEN;
    logic [AW-1:0] iaddr, daddr;
    logic [DW-1:0] dstore;
    logic [DW-1:0] iload, dload;
    logic          iwait, dwait;
    logic          ramREN, ramWEN;
    logic [AW-1:0] ramaddr;
    logic [DW-1:0] ramstore, ramload;
    logic          ramready;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramready(ramready)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // RAM model: read data is a fixed scramble of the address; ready after ram_lat strobe cycles.
    function automatic logic [DW-1:0] ram_data(input logic [AW-1:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    int   ram_lat = 1;
    int   ram_cnt = 0;
    logic ram_rdy = 1'b0;
    logic stray_rdy = 1'b0;

    assign ramload  = ram_data(ramaddr);
    assign ramready = ram_rdy | stray_rdy;

    always @(posedge CLK) begin
        #1;
        if (ramREN || ramWEN) begin
            ram_cnt = ram_rdy ? 1 : ram_cnt + 1;
            ram_rdy = (ram_cnt >= ram_lat);
        end else begin
            ram_cnt = 0;
            ram_rdy = 1'b0;
        end
    end

    typedef struct {
        logic          wr;
        logic          chk;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t iq[$];
    exp_t dq[$];
    bit   order_log[$];

    // Monitor: every completion must match the oldest outstanding expectation on that side.
    always @(negedge CLK) begin
        exp_t e;
        if (nRST) begin
            if (!dwait) begin
                order_log.push_back(1'b0);
                check("d_pending", dq.size() != 0, 1);
                if (dq.size() != 0) begin
                    e = dq.pop_front();
                    if (e.chk && e.wr) begin
                        check("d_wr_ramWEN", ramWEN, 1);
                        check("d_wr_ramREN", ramREN, 0);
                        check("d_wr_addr", ramaddr, e.addr);
                        check("d_wr_store", ramstore, e.data);
                    end else if (e.chk) begin
                        check("d_rd_ramREN", ramREN, 1);
                        check("d_rd_dload", dload, e.data);
                    end
                end
            end
            if (!iwait) begin
                order_log.push_back(1'b1);
                check("i_pending", iq.size() != 0, 1);
                if (iq.size() != 0) begin
                    e = iq.pop_front();
                    if (e.chk) check("i_rd_iload", iload, e.data);
                end
            end
        end
    end

    task automatic i_access(input logic [AW-1:0] a, output int cyc);
        bit done = 0;
        cyc = 0;
        iREN = 1'b1; iaddr = a;
        iq.push_back('{1'b0, 1'b1, a, ram_data(a)});
        for (int k = 1; k <= 50 && !done; k++) begin
            @(negedge CLK);
            if (!iwait) begin done = 1; cyc = k; end
        end
        check("i_done", done, 1);
        iREN = 1'b0;
    endtask

    task automatic d_access(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            output int cyc);
        bit done = 0;
        cyc = 0;
        dREN = !wr; dWEN = wr; daddr = a; dstore = d;
        dq.push_back('{wr, 1'b1, a, wr ? d : ram_data(a)});
        for (int k = 1; k <= 50 && !done; k++) begin
            @(negedge CLK);
            if (!dwait) begin done = 1; cyc = k; end
        end
        check("d_done", done, 1);
        dREN = 1'b0; dWEN = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        int          n;
        logic [9:0]  exp_order;
        nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0;

        #12;
        check("rst_ramREN", ramREN, 0);
        check("rst_ramWEN", ramWEN, 0);
        check("rst_ramaddr", ramaddr, 0);
        check("rst_ramstore", ramstore, 0);
        check("rst_iwait", iwait, 1);
        check("rst_dwait", dwait, 1);
        check("rst_iload", iload, 0);
        check("rst_dload", dload, 0);
        @(negedge CLK); nRST = 1'b1;
        @(negedge CLK);

        // Basic single accesses with various latencies.
        ram_lat = 1;
        i_access(32'h0000_0040, cyc);
        check("basic_i_lat1", cyc, 1);
        ram_lat = 2;
        d_access(1'b0, 32'h0000_0080, '0, cyc);
        check("basic_drd_lat2", cyc, 2);
        d_access(1'b1, 32'h0000_0084, 32'h1234_5678, cyc);
        check("basic_dwr_lat2", cyc, 2);
        @(negedge CLK);

        // Simultaneous requests: data first, instruction entered straight off data ready.
        iREN = 1'b1; iaddr = 32'h0000_1000;
        dREN = 1'b1; daddr = 32'h0000_2000;
        dq.push_back('{1'b0, 1'b1, 32'h0000_2000, ram_data(32'h0000_2000)});
        iq.push_back('{1'b0, 1'b1, 32'h0000_1000, ram_data(32'h0000_1000)});
        @(negedge CLK);
        check("sim_c1_dwait", dwait, 1);
        check("sim_c1_iwait", iwait, 1);
        check("sim_c1_ramaddr", ramaddr, 32'h0000_2000);
        @(negedge CLK);
        check("sim_c2_dwait", dwait, 0);
        dREN = 1'b0;
        @(negedge CLK);
        check("sim_c3_iwait", iwait, 1);
        check("sim_c3_ramREN", ramREN, 1);
        check("sim_c3_ramaddr", ramaddr, 32'h0000_1000);
        @(negedge CLK);
        check("sim_c4_iwait", iwait, 0);
        check("sim_c4_iload", iload, ram_data(32'h0000_1000));
        iREN = 1'b0;
        @(negedge CLK);
        check("sim_idle_ramREN", ramREN, 0);

        // Starvation bound: four data grants, then one forced fetch, repeating.
        ram_lat = 1;
        order_log.delete();
        iREN = 1'b1; iaddr = 32'h0000_3000;
        dREN = 1'b1; daddr = 32'h0000_4000;
        for (int k = 0; k < 8; k++) dq.push_back('{1'b0, 1'b1, 32'h0000_4000, ram_data(32'h0000_4000)});
        for (int k = 0; k < 2; k++) iq.push_back('{1'b0, 1'b1, 32'h0000_3000, ram_data(32'h0000_3000)});
        n = 0;
        for (int k = 0; k < 40 && n < 10; k++) begin
            @(negedge CLK);
            if (!dwait || !iwait) n++;
        end
        iREN = 1'b0; dREN = 1'b0;
        check("starve_count", n, 10);
        @(negedge CLK);
        check("starve_idle_ramREN", ramREN, 0);
        exp_order = 10'b10_0001_0000;
        check("starve_log_len", order_log.size(), 10);
        for (int k = 0; k < 10 && k < order_log.size(); k++)
            check($sformatf("starve_order_%0d", k), order_log[k], exp_order[k]);

        // Write precedence and latched address/data while daddr changes.
        ram_lat = 3;
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h0000_0100; dstore = 32'hDEAD_BEEF;
        dq.push_back('{1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF});
        for (int c = 1; c <= 3; c++) begin
            @(negedge CLK);
            check($sformatf("wr_c%0d_ramWEN", c), ramWEN, 1);
            check($sformatf("wr_c%0d_ramREN", c), ramREN, 0);
            check($sformatf("wr_c%0d_ramaddr", c), ramaddr, 32'h0000_0100);
            check($sformatf("wr_c%0d_ramstore", c), ramstore, 32'hDEAD_BEEF);
            if (c == 1) daddr = 32'h0000_0200;
        end
        check("wr_c3_dwait", dwait, 0);
        dREN = 1'b0; dWEN = 1'b0;
        @(negedge CLK);

        // Withdrawal: access runs to ramready, result discarded, re-issue waits its own latency.
        iREN = 1'b1; iaddr = 32'h0000_0500;
        iq.push_back('{1'b0, 1'b0, 32'h0000_0500, '0});
        @(negedge CLK);
        check("wd_c1_ramREN", ramREN, 1);
        check("wd_c1_ramaddr", ramaddr, 32'h0000_0500);
        check("wd_c1_iwait", iwait, 1);
        iREN = 1'b0;
        @(negedge CLK);
        check("wd_c2_ramREN", ramREN, 1);
        check("wd_c2_iwait", iwait, 1);
        @(negedge CLK);
        check("wd_c3_iwait", iwait, 0);
        @(negedge CLK);
        check("wd_c4_ramREN", ramREN, 0);
        check("wd_c4_iwait", iwait, 1);
        i_access(32'h0000_0600, cyc);
        check("wd_reissue_lat", cyc, 3);
        @(negedge CLK);

        // Stray ramready in IDLE is ignored.
        stray_rdy = 1'b1;
        #1;
        check("stray_iwait", iwait, 1);
        check("stray_dwait", dwait, 1);
        check("stray_iload", iload, 0);
        @(negedge CLK);
        check("stray_ramREN", ramREN, 0);
        check("stray_ramWEN", ramWEN, 0);
        check("stray_hold_addr", ramaddr, 32'h0000_0600);
        check("stray_iwait2", iwait, 1);
        stray_rdy = 1'b0;
        @(negedge CLK);

        // Reset mid-write: strobe and wait drop at once, no strobe afterwards until a new request.
        ram_lat = 4;
        dWEN = 1'b1; daddr = 32'h0000_0700; dstore = 32'h0BAD_F00D;
        @(negedge CLK);
        check("rst_mid_ramWEN_before", ramWEN, 1);
        #2 nRST = 1'b0;
        #1;
        check("rst_mid_ramWEN", ramWEN, 0);
        check("rst_mid_ramREN", ramREN, 0);
        check("rst_mid_dwait", dwait, 1);
        check("rst_mid_ramaddr", ramaddr, 0);
        check("rst_mid_ramstore", ramstore, 0);
        dWEN = 1'b0;
        @(negedge CLK);
        #2 nRST = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            check($sformatf("post_rst_%0d_strobes", c), {ramREN, ramWEN}, 2'b00);
        end
        d_access(1'b0, 32'h0000_0800, '0, cyc);
        check("post_rst_drd_lat4", cyc, 4);
        @(negedge CLK);

        check("iq_drained", iq.size(), 0);
        check("dq_drained", dq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single unified RAM port between the instruction-fetch side and the data-access side of the CPU datapath. Requests are served one at a time. Data accesses have priority, and a starvation counter bounds how long instruction fetch can wait. The block sits between the datapath's fetch/memory stages and the RAM model. It owns the request/wait handshake both sides stall on.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive data grants allowed while a fetch is pending before the fetch is forced; must be ≥1
- CLK  in  1  system clock, rising edge
- nRST  in  1  asynchronous active-low reset
- iREN  in  1  instruction read request
- iaddr  in  ADDR_W  instruction address
- iload  out  DATA_W  instruction read data
- iwait  out  1  1 = instruction request not yet complete
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  ADDR_W  data address
- dstore  in  DATA_W  data write value
- dload  out  DATA_W  data read data
- dwait  out  1  1 = data request not yet complete
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  DATA_W  RAM write data
- ramload  in  DATA_W  RAM read data
- ramready  in  1  RAM access complete this cycle (one-cycle pulse, latency ≥1)

## Operation
- States: IDLE, IGRANT, DGRANT.
- Registers: state, a latched op (addr, store data, write flag), and starve_cnt (width ⌈log2(STARVE_MAX+1)⌉).
- Grant selection (pick), evaluated in IDLE and on ramready in a grant state:
  - If a data request is present (dREN|dWEN) and not (iREN and starve_cnt==STARVE_MAX), go to DGRANT.
  - Else if iREN, go to IGRANT.
  - Else go to IDLE.
- On entering a grant state, latch the requester's address, store data and write flag from its current inputs.
- dWEN and dREN both high is treated as a write.
- starve_cnt behaviour:
  - Increments on each DGRANT entry while iREN=1, saturating at STARVE_MAX.
  - Clears on IGRANT entry, and on any DGRANT entry while iREN=0.
- RAM outputs:
  - ramREN=1 in IGRANT, and in DGRANT when the latched op is a read.
  - ramWEN=1 in DGRANT when the latched op is a write.
  - ramaddr and ramstore come from the latch.
  - In IDLE, both strobes are 0 and addr/store hold their last values.
- Requester outputs:
  - iwait = ~(state==IGRANT & ramready).
  - dwait = ~(state==DGRANT & ramready).
  - iload = ramload in IGRANT, else 0.
  - dload = ramload in DGRANT, else 0.
- Requester withdraws mid-access: the RAM access still runs to ramready. The result is discarded and pick runs normally. A write that was started is always completed.
- ramready in IDLE is ignored.

## Timing
- Request high at a rising edge while in IDLE: grant state and RAM strobes are valid from that edge onward, so there is no idle bubble.
- Minimum service latency is 1 cycle. wait drops in the same cycle as ramready (combinational path ramready→iwait/dwait and ramload→iload/dload).
- Back-to-back requests: on a ramready edge the arbiter moves directly into the next grant with no IDLE cycle.
- Requesters hold their request until they observe wait=0. A request still high on the edge after wait=0 is a new request.
- Reset (asynchronous, any time, including mid-access):
  - state=IDLE, starve_cnt=0, latch=0.
  - ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
  - iwait=1, dwait=1, iload=0, dload=0.
- No output may glitch high on ramREN/ramWEN during reset assertion.

## Test plan
- **Reset mid-access:**
  - Stimulus: drop nRST while in DGRANT with ramWEN=1.
  - Required: ramWEN=0 and dwait=1 immediately. After release, IDLE with no strobe until a new request.
- **Simultaneous requests:**
  - Stimulus: iREN=dREN=1, RAM latency 2, STARVE_MAX=4.
  - Required: data served first (dwait=0 in cycle 2), then IGRANT entered on that edge. iwait=0 in cycle 4 with iload=ramload.
- **Starvation bound:**
  - Stimulus: iREN held, dREN re-asserted after each completion, latency 1.
  - Required: exactly 4 data grants, then 1 instruction grant, then the pattern repeats.
- **Write precedence and latch:**
  - Stimulus: dREN=dWEN=1, daddr=0x100, dstore=0xDEADBEEF; change daddr to 0x200 during the access.
  - Required: ramWEN=1, ramREN=0, ramaddr=0x100, ramstore=0xDEADBEEF for the whole access.
- **Withdrawal:**
  - Stimulus: iREN deasserted after the grant, before ramready.
  - Required: ramREN stays high until ramready, then IDLE; iwait is never observed low by a re-issued request until its own ramready.
- **Stray ramready:**
  - Stimulus: pulse ramready in IDLE.
  - Required: no state change, and iwait=dwait=1.
